controlador_fifo: RTL and testbench
===================================

# controlador_fifo

Pointer and flag controller that turns the dual-read register bank into a first-word-fall-through FIFO queue. It accepts write/read requests from producer and consumer and drives the bank's write enable, write address and read address. It tracks occupancy, full/empty status and sticky overflow/underflow errors. It sits between the queue's external handshake and the register bank, one instance per queue.

## Interface
- `A`, default 4: address bits; depth D = 2**A words.
- `clk`  in  1  single system clock, all state updates on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `wr`  in  1  producer write request; data presented to bank `data_in` in the same cycle.
- `rd`  in  1  consumer read (pop) request; head word is read from bank `data_out2` in the same cycle.
- `clr_err`  in  1  synchronous clear of both error flags.
- `wr_en`  out  1  to bank write enable; combinational.
- `address_w`  out  A  to bank write address; equals write pointer (registered).
- `address_r`  out  A  to bank read address; equals read pointer (registered).
- `full`  out  1  registered, count == D.
- `empty`  out  1  registered, count == 0.
- `count`  out  A+1  registered occupancy, 0..D.
- `ovf_err`  out  1  sticky: write requested while full and not simultaneously read.
- `udf_err`  out  1  sticky: read requested while empty.

## Operation
- State: `w_ptr`[A-1:0], `r_ptr`[A-1:0], `count`[A:0], `ovf_err`, `udf_err`. `full`/`empty` are registered copies of the count compare, updated together with `count`.
- Accept rules, evaluated on current registered flags:
  - `wr_acc = wr & (!full | rd)`.
  - `rd_acc = rd & !empty`.
  - `wr_en = wr_acc`. It must never assert while full unless `rd` is also high.
- On each rising edge, when not in reset:
  - `wr_acc`: `w_ptr <= w_ptr + 1`, mod D with natural wrap at D-1 -> 0.
  - `rd_acc`: `r_ptr <= r_ptr + 1`, mod D.
  - `count`: +1 if `wr_acc` & !`rd_acc`; -1 if `rd_acc` & !`wr_acc`; unchanged if both or neither.
  - `full <= (next count == D)`; `empty <= (next count == 0)`.
- Full + wr + rd: both accepted. Write lands at `w_ptr == r_ptr`; the old head was already consumed combinationally this cycle. Count stays D.
- Empty + wr + rd: write accepted, read rejected, `udf_err` set. No pass-through; count becomes 1.
- Empty + rd only: nothing moves, `udf_err` set.
- Full + wr only: write dropped, `wr_en` = 0, `ovf_err` set.
- Errors are set-dominant over `clr_err` in the same cycle. `clr_err` clears only when no new error occurs that cycle.
- Reset, any time including mid-burst: pointers 0, `count` 0, `empty` 1, `full` 0, both errors 0. Contents of the bank are not cleared; data is simply abandoned. During reset, `wr_en` is forced 0.

## Timing
- Write latency: a word written at edge T is visible on the bank's `data_out2` from cycle T+1 if the queue was empty; `empty` deasserts in cycle T+1.
- Read is zero-latency (FWFT): the head word is valid whenever `empty` = 0. Asserting `rd` consumes it at the next edge, and the next word appears in the following cycle.
- Flag/count latency: exactly one cycle after the accepting edge. No combinational path from `wr`/`rd` to `full`, `empty` or `count`.
- Combinational paths: only `wr`/`rd` -> `wr_en`.
- Sustained simultaneous wr+rd at any non-empty occupancy gives 1 word/cycle throughput with constant count.

## Test plan
- Reset then idle, A=4: `empty`=1, `full`=0, `count`=0, `address_w`=`address_r`=0, `wr_en`=0, errors 0.
- Write 16 words 0x00..0x0F back-to-back, then 16 reads: `full`=1 after the 16th edge with `count`=16. Reads return 0x00..0x0F in order. `empty`=1 after the last read, and both pointers have wrapped to 0.
- Fill to 16, then a 17th write alone: `wr_en`=0, `count` stays 16, `ovf_err`=1 next cycle. Then pulse `clr_err`: `ovf_err`=0.
- Full + wr=rd=1 with data 0xAA: `wr_en`=1, `count`=16. Next 16 reads return old words 1..15 then 0xAA.
- Empty + wr=rd=1 with 0x55: `count`=1, `udf_err`=1, head = 0x55 next cycle. Empty + rd alone: pointers unchanged.
- Assert `reset` with `count`=7 while wr=1: next cycle `count`=0, `empty`=1, pointers 0, `wr_en`=0 during reset.

Source files
------------

// File: rtl/controlador_fifo.sv
// Pointer/flag controller turning a dual-read register bank into a FWFT queue.
// Flags, count and pointers are registered; only wr/rd -> wr_en is combinational.
module controlador_fifo #(
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic         clr_err,
    output logic         wr_en,
    output logic [A-1:0] address_w,
    output logic [A-1:0] address_r,
    output logic         full,
    output logic         empty,
    output logic [A:0]   count,
    output logic         ovf_err,
    output logic         udf_err
);

    localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};

    logic [A-1:0] w_ptr_q, w_ptr_d;
    logic [A-1:0] r_ptr_q, r_ptr_d;
    logic [A:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         wr_acc, rd_acc, ovf_set, udf_set;

    // A read in the same cycle frees the slot, so a full queue still accepts a write.
    assign wr_acc  = wr & (~full_q | rd);
    assign rd_acc  = rd & ~empty_q;
    assign ovf_set = wr & full_q & ~rd;
    assign udf_set = rd & empty_q;

    always_comb begin
        w_ptr_d = wr_acc ? w_ptr_q + A'(1) : w_ptr_q;
        r_ptr_d = rd_acc ? r_ptr_q + A'(1) : r_ptr_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (A+1)'(1);
            2'b01:   count_d = count_q - (A+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0);
        // New errors win over a same-cycle clear.
        ovf_d   = ovf_set | (ovf_q & ~clr_err);
        udf_d   = udf_set | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wr_en     = wr_acc & ~reset;
    assign address_w = w_ptr_q;
    assign address_r = r_ptr_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;

endmodule

// File: tb/tb_controlador_fifo.sv
// Randomised and directed bench for controlador_fifo against a queue-based reference model.
module tb_controlador_fifo;

    localparam int A = 4;
    localparam int D = 1 << A;

    logic         clk = 1'b0;
    logic         reset, wr, rd, clr_err;
    logic         wr_en, full, empty, ovf_err, udf_err;
    logic [A-1:0] address_w, address_r;
    logic [A:0]   count;
    logic [7:0]   din;
    logic [7:0]   bank [D];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the queue contents, pointer totals and error flags.
    logic [7:0] q [$];
    int         wtot, rtot;
    bit         ovf_m, udf_m;

    controlador_fifo #(.A(A)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .wr_en(wr_en), .address_w(address_w), .address_r(address_r),
        .full(full), .empty(empty), .count(count),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    // Behavioural register bank driven by the controller.
    always @(posedge clk) if (wr_en) bank[address_w] <= din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == D));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("address_w", 32'(address_w), 32'(wtot % D));
        chk("address_r", 32'(address_r), 32'(rtot % D));
        chk("ovf_err", 32'(ovf_err), 32'(ovf_m));
        chk("udf_err", 32'(udf_err), 32'(udf_m));
    endtask

    // One clock: drive at negedge, check comb outputs, clock, then check registered state.
    task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit wa, ra, os, us;
        wr = w; rd = r; clr_err = c; din = d; reset = 1'b0;
        wa = w && (q.size() < D || r);
        ra = r && q.size() > 0;
        os = w && q.size() == D && !r;
        us = r && q.size() == 0;
        #1;
        chk("wr_en", 32'(wr_en), 32'(wa));
        if (q.size() > 0) chk("head", 32'(bank[address_r]), 32'(q[0]));
        @(posedge clk);
        if (ra) begin void'(q.pop_front()); rtot++; end
        if (wa) begin q.push_back(d); wtot++; end
        ovf_m = os || (ovf_m && !c);
        udf_m = us || (udf_m && !c);
        @(negedge clk);
        chk_state();
    endtask

    task automatic do_reset(input bit w);
        reset = 1'b1; wr = w; rd = 1'b0; clr_err = 1'b0; din = 8'hEE;
        #1;
        chk("wr_en_in_reset", 32'(wr_en), 32'd0);
        @(posedge clk);
        q.delete(); wtot = 0; rtot = 0; ovf_m = 1'b0; udf_m = 1'b0;
        @(negedge clk);
        reset = 1'b0; wr = 1'b0;
        chk_state();
    endtask

    initial begin
        int pw;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;
        wtot = 0; rtot = 0; ovf_m = 1'b0; udf_m = 1'b0;
        @(negedge clk);
        do_reset(1'b0);
        cyc(0, 0, 0, 8'h00);

        // Fill and drain in order, pointers wrap back to 0.
        for (int i = 0; i < D; i++) cyc(1, 0, 0, 8'(i));
        chk("full_after_fill", 32'(full), 32'd1);
        for (int i = 0; i < D; i++) cyc(0, 1, 0, 8'h00);
        chk("empty_after_drain", 32'(empty), 32'd1);
        chk("wptr_wrapped", 32'(address_w), 32'd0);

        // Overflow on a lone write while full, then clear.
        for (int i = 0; i < D; i++) cyc(1, 0, 0, 8'(i));
        cyc(1, 0, 0, 8'hF0);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        cyc(0, 0, 1, 8'h00);
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        // Error set wins over a same-cycle clear.
        cyc(1, 0, 1, 8'hF1);
        chk("ovf_set_dominant", 32'(ovf_err), 32'd1);

        // Full with simultaneous write and read.
        cyc(1, 1, 0, 8'hAA);
        chk("count_full_wr_rd", 32'(count), 32'(D));
        for (int i = 0; i < D; i++) cyc(0, 1, 1, 8'h00);

        // Empty with simultaneous write and read: no pass-through.
        cyc(1, 1, 0, 8'h55);
        chk("udf_on_empty_wr_rd", 32'(udf_err), 32'd1);
        chk("head_55", 32'(bank[address_r]), 32'h55);
        cyc(0, 1, 1, 8'h00);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);

        // Reset mid-burst with wr held high.
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 8'(8'h30 + i));
        chk("count_7", 32'(count), 32'd7);
        do_reset(1'b1);

        // Randomised phases with varying write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(999) < 4) do_reset($urandom_range(1) == 1);
                else cyc($urandom_range(99) < pw, $urandom_range(99) < (100 - pw),
                         $urandom_range(99) < 5, 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
